// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and default operand width
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_MULU = 4'b1001,
    OP_DIVU = 4'b1010,
    OP_NOTA = 4'b1100
  } alu_op_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative unsigned shift-add multiply / restoring divide
// acc_next_o is the state after the current step; the top captures it on the last step.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] acc_next_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;

  assign hi     = acc_q[2*WIDTH-1:WIDTH];
  assign lo     = acc_q[WIDTH-1:0];
  assign last_o = (cnt_q == CW'(WIDTH - 1));

  // Mul: hi accumulates, lo holds the multiplier shifting out. Div: hi is the
  // partial remainder, lo shifts dividend bits out and quotient bits in.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      acc_next_o = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), lo[WIDTH-2:0], div_ge};
    end else begin
      acc_next_o = {mul_sum, lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
    end else if (load_i) begin
      cnt_q    <= '0;
      is_div_q <= is_div_i;
      opnd_q   <= is_div_i ? b_i : a_i;
      acc_q    <= {{WIDTH{1'b0}}, (is_div_i ? a_i : b_i)};
    end else if (step_i) begin
      cnt_q    <= cnt_q + 1'b1;
      acc_q    <= acc_next_o;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - ALU with single-cycle logic/arith ops and iterative MULU/DIVU
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state_q;
  logic               busy_q, done_q, zero_q;
  logic [WIDTH-1:0]   result_q, result_hi_q;
  logic [WIDTH-1:0]   alu_d;
  logic               accept;
  logic               md_last;
  logic [2*WIDTH-1:0] md_next;

  assign accept    = start && (state_q != S_BUSY);
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;

  always_comb begin
    alu_d = '0;
    case (alu_op_t'(ctrl))
      OP_AND:  alu_d = a & b;
      OP_OR:   alu_d = a | b;
      OP_ADD:  alu_d = a + b;
      OP_SUB:  alu_d = a - b;
      OP_XOR:  alu_d = a ^ b;
      OP_NOTA: alu_d = ~a;
      OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_d = '0;
    endcase
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept && is_iterative(ctrl)),
    .step_i     (state_q == S_BUSY),
    .is_div_i   (ctrl == OP_DIVU),
    .a_i        (a),
    .b_i        (b),
    .last_o     (md_last),
    .acc_next_o (md_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
    end else begin
      case (state_q)
        S_BUSY: begin
          if (md_last) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= md_next[WIDTH-1:0];
            result_hi_q <= md_next[2*WIDTH-1:WIDTH];
            zero_q      <= (md_next[WIDTH-1:0] == '0);
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE with start gives back-to-back results.
          if (start && is_iterative(ctrl)) begin
            state_q <= S_BUSY;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else if (start) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            result_q    <= alu_d;
            result_hi_q <= '0;
            zero_q      <= (alu_d == '0);
          end else begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle with a behavioural model
module tb_alu_multicycle;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [W-1:0]  a, b;
  logic [3:0]    ctrl;
  logic          busy, done, zero;
  logic [W-1:0]  result, result_hi;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  int   busy_lo = -1;
  int   busy_hi = -2;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain arithmetic on wide integers
  task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic [W-1:0] h);
    logic [2*W-1:0] p;
    r = '0;
    h = '0;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = (x < y) ? 1 : 0;
      4'b1100: r = ~x;
      4'b0011: r = x ^ y;
      4'b1000: r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'b1001: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        r = p[W-1:0];
        h = p[2*W-1:W];
      end
      4'b1010: begin
        if (y == 0) begin
          r = '1;
          h = x;
        end else begin
          r = x / y;
          h = x % y;
        end
      end
      default: ;
    endcase
  endtask

  // Monitor: samples one time unit after the active edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      chk("busy", {63'd0, busy}, {63'd0, (cyc >= busy_lo && cyc <= busy_hi)});
      if (done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done at cycle %0d: got done=1, expected done=0", cyc);
        end else begin
          e = sb.pop_front();
          chk("result", {32'd0, result}, {32'd0, e.res});
          chk("result_hi", {32'd0, result_hi}, {32'd0, e.hi});
          chk("zero", {63'd0, zero}, {63'd0, (e.res == 0)});
          chk("done_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        e = sb.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_done at cycle %0d: got done=0, expected done=1", cyc);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge of the DONE cycle.
  task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                      input bit junk);
    exp_t e;
    bit   iter;
    iter = (op == 4'b1001) || (op == 4'b1010);
    start = 1'b1;
    ctrl  = op;
    a     = x;
    b     = y;
    model(op, x, y, e.res, e.hi);
    e.due = cyc + 1 + (iter ? W : 0);
    sb.push_back(e);
    if (iter) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + W;
    end
    @(negedge clk);
    if (iter) begin
      repeat (W) begin
        start = junk;
        ctrl  = 4'b0010;
        a     = $urandom;
        b     = $urandom;
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corner [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 255));
    return $urandom;
  endfunction

  initial begin
    logic [3:0] ops [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111,
                             4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b0100, 4'b1111};
    int c0;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    ctrl  = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_result", {32'd0, result}, 64'd0);
    chk("reset_result_hi", {32'd0, result_hi}, 64'd0);
    chk("reset_zero", {63'd0, zero}, 64'd1);
    reset  = 1'b0;
    mon_en = 1'b1;

    send(4'b0010, 32'hFFFF_FFFF, 32'h1, 1'b0);
    idle(2);
    send(4'b1000, 32'hFFFF_FFFF, 32'h1, 1'b0);
    send(4'b0111, 32'hFFFF_FFFF, 32'h1, 1'b0);
    send(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(4'b0010, 32'd40, 32'd2, 1'b0);
    send(4'b1010, 32'd100, 32'd7, 1'b0);
    send(4'b1010, 32'd5, 32'd0, 1'b0);
    idle(2);

    // Abort a divide at its tenth busy cycle
    c0      = cyc;
    start   = 1'b1;
    ctrl    = 4'b1010;
    a       = 32'd1000;
    b       = 32'd3;
    busy_lo = c0 + 1;
    busy_hi = c0 + W;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset   = 1'b1;
    busy_hi = cyc;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_result", {32'd0, result}, 64'd0);
    chk("abort_result_hi", {32'd0, result_hi}, 64'd0);
    chk("abort_zero", {63'd0, zero}, 64'd1);
    reset = 1'b0;
    idle(W + 5);

    for (int i = 0; i < 150; i++) begin
      send(ops[$urandom_range(0, 11)], pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);
    for (int i = 0; i < W + 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending results, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
